// File: rtl/frog_collision_monitor_pkg.sv
// Shared definitions for the frog collision monitor: FSM states, screen and
// sprite geometry, lives width and a saturating lives increment helper.
package frog_collision_monitor_pkg;

  localparam int unsigned H_VISIBLE_AREA = 640;
  localparam int unsigned V_VISIBLE_AREA = 480;
  localparam int unsigned TILE_SIZE      = 32;
  localparam int unsigned LIVES_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PLAYING,
    ST_GRACE,
    ST_GAME_OVER
  } state_e;

  // Add one life, holding at the ceiling.
  function automatic logic [LIVES_W-1:0] lives_sat_inc(
    input logic [LIVES_W-1:0] lives,
    input logic [LIVES_W-1:0] ceil
  );
    if (lives >= ceil) begin
      return ceil;
    end
    return lives + LIVES_W'(1);
  endfunction

endpackage

// File: rtl/frog_collision_monitor_hitbox_compare.sv
// Combinational test of whether the current scan pixel lies inside the frog's
// inset hitbox and inside the visible area. All sums are 11 bits so a frog
// near the right/bottom edge never wraps around to column/row 0.
module frog_hitbox_compare
  import frog_collision_monitor_pkg::*;
#(
  parameter int unsigned P_TILE_SIZE    = TILE_SIZE,
  parameter int unsigned P_HITBOX_INSET = 4,
  parameter int unsigned P_H_VISIBLE    = H_VISIBLE_AREA,
  parameter int unsigned P_V_VISIBLE    = V_VISIBLE_AREA
) (
  input  logic [9:0] i_H_Count,
  input  logic [9:0] i_V_Count,
  input  logic [9:0] i_Frog_X,
  input  logic [8:0] i_Frog_Y,
  output logic       o_In_Box
);

  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic [10:0] x_lo;
  logic [10:0] x_hi;
  logic [10:0] y_lo;
  logic [10:0] y_hi;

  // Hitbox bounds and in-box decision for the current scan pixel.
  always_comb begin
    h_ext    = {1'b0, i_H_Count};
    v_ext    = {1'b0, i_V_Count};
    x_lo     = {1'b0, i_Frog_X} + 11'(P_HITBOX_INSET);
    x_hi     = {1'b0, i_Frog_X} + 11'(P_TILE_SIZE - P_HITBOX_INSET);
    y_lo     = {2'b00, i_Frog_Y} + 11'(P_HITBOX_INSET);
    y_hi     = {2'b00, i_Frog_Y} + 11'(P_TILE_SIZE - P_HITBOX_INSET);
    o_In_Box = (h_ext >= x_lo) && (h_ext < x_hi) &&
               (v_ext >= y_lo) && (v_ext < y_hi) &&
               (h_ext < 11'(P_H_VISIBLE)) && (v_ext < 11'(P_V_VISIBLE));
  end

endmodule

// File: rtl/frog_collision_monitor.sv
// Frog collision detector and lives tracker. Latches frog/car overlap during
// a frame, evaluates it at the frame-end strobe and manages lives, grace
// period and game-over.
// Optional feature: define FROG_EXTRA_LIFE_EN to let i_Level_Up award lives.
module frog_collision_monitor
  import frog_collision_monitor_pkg::*;
#(
  parameter int unsigned C_LIVES_INI  = 3,
  parameter int unsigned C_LIVES_MAX  = 7,
  parameter int unsigned HITBOX_INSET = 4,
  parameter int unsigned GRACE_FRAMES = 60
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Game_Active,
  input  logic [9:0]         i_H_Count,
  input  logic [9:0]         i_V_Count,
  input  logic [9:0]         i_Frog_X,
  input  logic [8:0]         i_Frog_Y,
  input  logic               i_Car_Pixel,
  input  logic               i_Level_Up,
  output logic               o_Has_Collided,
  output logic               o_End_Game,
  output logic [LIVES_W-1:0] o_Lives
);

  localparam int unsigned GRACE_W = (GRACE_FRAMES < 1) ? 1 : $clog2(GRACE_FRAMES + 1);
  localparam logic [GRACE_W-1:0] GRACE_INIT = GRACE_W'(GRACE_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_INI  = LIVES_W'(C_LIVES_INI);
  localparam logic [LIVES_W-1:0] LIVES_MAX  = LIVES_W'(C_LIVES_MAX);

  state_e               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [GRACE_W-1:0]   grace_q, grace_d;
  logic                 latch_q, latch_d;
  logic                 has_collided_q, has_collided_d;

  logic                 in_box;
  logic                 frame_end;
  logic                 level_up;

  frog_hitbox_compare #(
    .P_TILE_SIZE    (TILE_SIZE),
    .P_HITBOX_INSET (HITBOX_INSET),
    .P_H_VISIBLE    (H_VISIBLE_AREA),
    .P_V_VISIBLE    (V_VISIBLE_AREA)
  ) u_hitbox (
    .i_H_Count (i_H_Count),
    .i_V_Count (i_V_Count),
    .i_Frog_X  (i_Frog_X),
    .i_Frog_Y  (i_Frog_Y),
    .o_In_Box  (in_box)
  );

`ifdef FROG_EXTRA_LIFE_EN
  // Level-up pulses are honoured as extra-life requests.
  always_comb begin
    level_up = i_Level_Up;
  end
`else
  logic unused_level_up;

  // Level-up has no effect on lives in this build.
  always_comb begin
    level_up        = 1'b0;
    unused_level_up = i_Level_Up;
  end
`endif

  // Frame-end strobe: first column of the first non-visible row.
  always_comb begin
    frame_end = (i_V_Count == 10'(V_VISIBLE_AREA)) && (i_H_Count == '0);
  end

  // State, lives, grace counter, overlap latch and hit pulse registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q        <= ST_IDLE;
      lives_q        <= LIVES_INI;
      grace_q        <= '0;
      latch_q        <= 1'b0;
      has_collided_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      grace_q        <= grace_d;
      latch_q        <= latch_d;
      has_collided_q <= has_collided_d;
    end
  end

  // Next state plus lives/grace bookkeeping. Hit and level-up on the same
  // edge cancel in lives but still produce the hit pulse and a grace period.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    grace_d        = grace_q;
    has_collided_d = 1'b0;
    latch_d        = frame_end ? 1'b0 : (latch_q | (in_box & i_Car_Pixel));

    unique case (state_q)
      ST_IDLE: begin
        if (i_Game_Active) begin
          state_d = ST_PLAYING;
        end
      end

      ST_PLAYING: begin
        if (!i_Game_Active) begin
          state_d = ST_IDLE;
          grace_d = '0;
        end else if (frame_end && latch_q && (lives_q != '0)) begin
          has_collided_d = 1'b1;
          if (level_up) begin
            state_d = ST_GRACE;
            grace_d = GRACE_INIT;
          end else begin
            lives_d = lives_q - LIVES_W'(1);
            if (lives_q == LIVES_W'(1)) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d = ST_GRACE;
              grace_d = GRACE_INIT;
            end
          end
        end else if (level_up) begin
          lives_d = lives_sat_inc(lives_q, LIVES_MAX);
        end
      end

      ST_GRACE: begin
        if (!i_Game_Active) begin
          state_d = ST_IDLE;
          grace_d = '0;
        end else begin
          if (level_up) begin
            lives_d = lives_sat_inc(lives_q, LIVES_MAX);
          end
          if (frame_end) begin
            if (grace_q <= GRACE_W'(1)) begin
              grace_d = '0;
              state_d = ST_PLAYING;
            end else begin
              grace_d = grace_q - GRACE_W'(1);
            end
          end
        end
      end

      ST_GAME_OVER: begin
        if (!i_Game_Active) begin
          state_d = ST_IDLE;
          lives_d = LIVES_INI;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: registered hit pulse, game-over level, lives count.
  always_comb begin
    o_Has_Collided = has_collided_q;
    o_End_Game     = (state_q == ST_GAME_OVER);
    o_Lives        = lives_q;
  end

endmodule
